// File: rtl/j_xmem.sv
// External-bus master sequencer: runs one IW-bit internal transfer as 1..8
// dtack-terminated EW-bit beats, with grant handshake, lane steering and dtack timeout.
module j_xmem #(
  parameter int unsigned IW  = 32,
  parameter int unsigned EW  = 16,
  parameter int unsigned AW  = 24,
  parameter int unsigned TMO = 255
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          mreq,
  input  logic          rw,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] wdata,
  input  logic          bigend,
  input  logic          dbgl,
  input  logic          dtackl,
  input  logic [EW-1:0] ed_i,
  output logic          ack,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] rdata,
  output logic          dreql,
  output logic [AW-1:0] ea,
  output logic [EW-1:0] ed_o,
  output logic          ed_oe,
  output logic          erw,
  output logic          strb
);

  localparam int unsigned EB  = EW / 8;
  localparam int unsigned EBL = $clog2(EB);
  localparam int unsigned TW  = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEAT, S_GAP, S_DONE} state_t;

  state_t        state_q;
  logic          rw_q, bigend_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [IW-1:0] wdata_q;
  logic [3:0]    nb_q;
  logic [2:0]    k_q;
  logic [TW-1:0] tmo_q;
  logic [IW-1:0] acc_q;
  logic          ack_q, done_q, err_q, dreql_q, ed_oe_q, erw_q, strb_q;
  logic [IW-1:0] rdata_q;
  logic [AW-1:0] ea_q;
  logic [EW-1:0] ed_o_q;

  // Request qualification from the live request fields
  logic [31:0] req_bytes;
  logic        req_bad;
  logic [3:0]  req_nb;

  always_comb begin
    req_bytes = 32'(1) << size;
    req_bad   = ((32'(addr) & (req_bytes - 32'd1)) != 32'd0) || (size == 2'd3 && IW < 64);
    req_nb    = (req_bytes <= EB) ? 4'd1 : 4'(req_bytes >> EBL);
  end

  // Per-beat address, write lane data and read merge for beat k_q
  logic [31:0]   cur_bytes, cur_lane, cur_lbits;
  logic          cur_sub;
  logic [2:0]    chunk;
  logic [AW-1:0] ea_d;
  logic [EW-1:0] ed_o_d;
  logic [IW-1:0] acc_d;

  always_comb begin
    cur_bytes = 32'(1) << size_q;
    cur_sub   = cur_bytes < EB;
    cur_lbits = 32'(8) << size_q;
    cur_lane  = (32'(addr_q) & (EB - 32'd1)) >> size_q;
    if (bigend_q) cur_lane = (EB >> size_q) - 32'd1 - cur_lane;
    chunk  = bigend_q ? 3'(nb_q - 4'(k_q) - 4'd1) : k_q;
    ea_d   = addr_q + AW'(32'(k_q) * EB);
    ed_o_d = EW'(wdata_q >> (32'(chunk) * EW));
    acc_d  = acc_q | (IW'(ed_i) << (32'(chunk) * EW));
    if (cur_sub) begin
      // Narrow transfers: writes replicate the item, reads pick one lane
      for (int unsigned i = 0; i < EB; i++) begin
        ed_o_d[8*i +: 8] = wdata_q[8*(i & (cur_bytes - 32'd1)) +: 8];
      end
      acc_d = IW'(ed_i >> (cur_lane * cur_lbits)) & ((IW'(1) << cur_lbits) - IW'(1));
    end
  end

  logic start_beat;
  assign start_beat = (state_q == S_REQ || state_q == S_GAP) && !dbgl;

  always_ff @(posedge clk) begin
    if (!resetl) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b1;
      bigend_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      nb_q     <= 4'd1;
      k_q      <= 3'd0;
      tmo_q    <= '0;
      acc_q    <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dreql_q  <= 1'b1;
      ed_oe_q  <= 1'b0;
      erw_q    <= 1'b1;
      strb_q   <= 1'b0;
      rdata_q  <= '0;
      ea_q     <= '0;
      ed_o_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        // DONE accepts a queued request directly so the bus is never released
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          dreql_q <= 1'b1;
          if (mreq) begin
            ack_q <= 1'b1;
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= S_REQ;
              dreql_q  <= 1'b0;
              rw_q     <= rw;
              size_q   <= size;
              addr_q   <= addr;
              wdata_q  <= wdata;
              bigend_q <= bigend;
              nb_q     <= req_nb;
              k_q      <= 3'd0;
              acc_q    <= '0;
            end
          end
        end
        S_REQ, S_GAP: state_q <= dbgl ? S_REQ : S_BEAT;
        S_BEAT: begin
          if (!dtackl) begin
            strb_q  <= 1'b0;
            ed_oe_q <= 1'b0;
            erw_q   <= 1'b1;
            acc_q   <= acc_d;
            if (k_q == 3'(nb_q - 4'd1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (rw_q) rdata_q <= acc_d;
            end else begin
              state_q <= S_GAP;
              k_q     <= k_q + 3'd1;
            end
          end else if (TMO != 0 && tmo_q == TW'(TMO - 1)) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            dreql_q <= 1'b1;
            strb_q  <= 1'b0;
            ed_oe_q <= 1'b0;
            erw_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (start_beat) begin
        strb_q  <= 1'b1;
        ed_oe_q <= ~rw_q;
        erw_q   <= rw_q;
        ea_q    <= ea_d;
        ed_o_q  <= ed_o_d;
        tmo_q   <= '0;
      end
    end
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign dreql = dreql_q;
  assign ea    = ea_q;
  assign ed_o  = ed_o_q;
  assign ed_oe = ed_oe_q;
  assign erw   = erw_q;
  assign strb  = strb_q;

endmodule

// File: tb/tb_j_xmem.sv
// Directed bench for j_xmem: a 32-on-16 instance driven from a vector table plus
// hand sequences, and a 64-on-8 instance for the eight-beat cases.
module tb_j_xmem;

  logic clk, resetl;

  logic        a_mreq, a_rw, a_be, a_dbgl, a_dtackl;
  logic [1:0]  a_size;
  logic [23:0] a_addr;
  logic [31:0] a_wdata;
  logic [15:0] a_edi;
  logic        a_ack, a_done, a_err, a_dreql, a_edoe, a_erw, a_strb;
  logic [31:0] a_rdata;
  logic [23:0] a_ea;
  logic [15:0] a_edo;

  logic        b_mreq, b_rw, b_be, b_dbgl, b_dtackl;
  logic [1:0]  b_size;
  logic [23:0] b_addr;
  logic [63:0] b_wdata;
  logic [7:0]  b_edi;
  logic        b_ack, b_done, b_err, b_dreql, b_edoe, b_erw, b_strb;
  logic [63:0] b_rdata;
  logic [23:0] b_ea;
  logic [7:0]  b_edo;

  int n_tests = 0;
  int n_fail  = 0;

  j_xmem #(.IW(32), .EW(16), .AW(24), .TMO(4)) u_a (
    .clk(clk), .resetl(resetl), .mreq(a_mreq), .rw(a_rw), .size(a_size), .addr(a_addr),
    .wdata(a_wdata), .bigend(a_be), .dbgl(a_dbgl), .dtackl(a_dtackl), .ed_i(a_edi),
    .ack(a_ack), .done(a_done), .err(a_err), .rdata(a_rdata), .dreql(a_dreql), .ea(a_ea),
    .ed_o(a_edo), .ed_oe(a_edoe), .erw(a_erw), .strb(a_strb));

  j_xmem #(.IW(64), .EW(8), .AW(24), .TMO(4)) u_b (
    .clk(clk), .resetl(resetl), .mreq(b_mreq), .rw(b_rw), .size(b_size), .addr(b_addr),
    .wdata(b_wdata), .bigend(b_be), .dbgl(b_dbgl), .dtackl(b_dtackl), .ed_i(b_edi),
    .ack(b_ack), .done(b_done), .err(b_err), .rdata(b_rdata), .dreql(b_dreql), .ea(b_ea),
    .ed_o(b_edo), .ed_oe(b_edoe), .erw(b_erw), .strb(b_strb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        be;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [15:0] bus0, bus1;
    int          nb;
    logic [23:0] ea0, ea1;
    logic [15:0] d0, d1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[13];

  // One zero-wait transfer on instance A; mreq is cycle 0, done lands in cycle 1+2*NB
  task automatic run_a(input vec_t v, input int idx);
    int beats = 0;
    int done_cyc = -1;
    logic err_seen = 1'b0;
    int maxc = v.err ? 6 : 30;
    @(negedge clk);
    a_mreq = 1'b1; a_rw = v.rw; a_size = v.size; a_addr = v.addr;
    a_wdata = v.wdata; a_be = v.be;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk($sformatf("v%0d ack", idx), 64'(a_ack), 64'(1'b1));
        chk($sformatf("v%0d err@ack", idx), 64'(a_err), 64'(v.err));
        a_mreq = 1'b0;
      end
      if (a_strb) begin
        if (beats < 2) begin
          chk($sformatf("v%0d ea%0d", idx, beats), 64'(a_ea), 64'(beats == 0 ? v.ea0 : v.ea1));
          chk($sformatf("v%0d oe%0d", idx, beats), 64'(a_edoe), 64'(!v.rw));
          if (!v.rw)
            chk($sformatf("v%0d ed_o%0d", idx, beats), 64'(a_edo), 64'(beats == 0 ? v.d0 : v.d1));
          a_edi = (beats == 0) ? v.bus0 : v.bus1;
        end
        beats++;
      end
      if (a_err) err_seen = 1'b1;
      if (a_done) begin
        done_cyc = cyc;
        if (v.rw) chk($sformatf("v%0d rdata", idx), 64'(a_rdata), 64'(v.rdata));
        break;
      end
    end
    chk($sformatf("v%0d beats", idx), 64'(beats), 64'(v.nb));
    chk($sformatf("v%0d done cycle", idx), 64'(done_cyc), 64'(v.err ? -1 : 1 + 2 * v.nb));
    chk($sformatf("v%0d err seen", idx), 64'(err_seen), 64'(v.err));
  endtask

  // Eight-beat transfer on instance B; bus returns 0x11,0x22,.. for beats 0..7
  task automatic run_b(input string nm, input logic rw, input logic be, input logic [23:0] addr,
                       input logic [63:0] wdata, input logic [7:0][7:0] expd,
                       input logic [63:0] exp_rd);
    int beats = 0;
    int done_cyc = -1;
    @(negedge clk);
    b_mreq = 1'b1; b_rw = rw; b_be = be; b_size = 2'd3; b_addr = addr; b_wdata = wdata;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({nm, " ack"}, 64'(b_ack), 64'(1'b1));
        b_mreq = 1'b0;
      end
      if (b_strb) begin
        if (beats < 8) begin
          chk($sformatf("%s ea%0d", nm, beats), 64'(b_ea), 64'(addr + 24'(beats)));
          if (!rw) chk($sformatf("%s ed_o%0d", nm, beats), 64'(b_edo), 64'(expd[beats]));
        end
        b_edi = 8'(8'h11 * (beats + 1));
        beats++;
      end
      if (b_done) begin
        done_cyc = cyc;
        if (rw) chk({nm, " rdata"}, b_rdata, exp_rd);
        break;
      end
    end
    chk({nm, " beats"}, 64'(beats), 64'(8));
    chk({nm, " done cycle"}, 64'(done_cyc), 64'(17));
  endtask

  initial begin
    int cnt, ecyc, dcyc;
    logic dr_at_err, any_bad;

    // rw size be addr wdata bus0 bus1 nb ea0 ea1 d0 d1 rdata err
    vt[0]  = '{1'b1, 2'd2, 1'b1, 24'h100, 32'h0, 16'h1234, 16'h5678, 2, 24'h100, 24'h102, 16'h0, 16'h0, 32'h12345678, 1'b0};
    vt[1]  = '{1'b1, 2'd2, 1'b0, 24'h200, 32'h0, 16'h1234, 16'h5678, 2, 24'h200, 24'h202, 16'h0, 16'h0, 32'h56781234, 1'b0};
    vt[2]  = '{1'b0, 2'd2, 1'b1, 24'h300, 32'hCAFEBABE, 16'h0, 16'h0, 2, 24'h300, 24'h302, 16'hCAFE, 16'hBABE, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 24'h304, 32'hCAFEBABE, 16'h0, 16'h0, 2, 24'h304, 24'h306, 16'hBABE, 16'hCAFE, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 2'd0, 1'b1, 24'h201, 32'h0, 16'hAABB, 16'h0, 1, 24'h201, 24'h0, 16'h0, 16'h0, 32'hBB, 1'b0};
    vt[5]  = '{1'b1, 2'd0, 1'b0, 24'h201, 32'h0, 16'hAABB, 16'h0, 1, 24'h201, 24'h0, 16'h0, 16'h0, 32'hAA, 1'b0};
    vt[6]  = '{1'b1, 2'd0, 1'b1, 24'h200, 32'h0, 16'hAABB, 16'h0, 1, 24'h200, 24'h0, 16'h0, 16'h0, 32'hAA, 1'b0};
    vt[7]  = '{1'b0, 2'd0, 1'b1, 24'h203, 32'h45, 16'h0, 16'h0, 1, 24'h203, 24'h0, 16'h4545, 16'h0, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 2'd1, 1'b1, 24'h204, 32'h0, 16'hBEEF, 16'h0, 1, 24'h204, 24'h0, 16'h0, 16'h0, 32'hBEEF, 1'b0};
    vt[9]  = '{1'b0, 2'd1, 1'b0, 24'h206, 32'h1357, 16'h0, 16'h0, 1, 24'h206, 24'h0, 16'h1357, 16'h0, 32'h0, 1'b0};
    vt[10] = '{1'b1, 2'd2, 1'b1, 24'h102, 32'h0, 16'h0, 16'h0, 0, 24'h0, 24'h0, 16'h0, 16'h0, 32'h0, 1'b1};
    vt[11] = '{1'b0, 2'd1, 1'b0, 24'h101, 32'h0, 16'h0, 16'h0, 0, 24'h0, 24'h0, 16'h0, 16'h0, 32'h0, 1'b1};
    vt[12] = '{1'b1, 2'd3, 1'b0, 24'h000, 32'h0, 16'h0, 16'h0, 0, 24'h0, 24'h0, 16'h0, 16'h0, 32'h0, 1'b1};

    resetl = 1'b0;
    a_mreq = 1'b1; a_rw = 1'b1; a_size = 2'd2; a_addr = 24'h0; a_wdata = 32'h0; a_be = 1'b1;
    a_dbgl = 1'b0; a_dtackl = 1'b0; a_edi = 16'h0;
    b_mreq = 1'b1; b_rw = 1'b1; b_size = 2'd3; b_addr = 24'h0; b_wdata = 64'h0; b_be = 1'b0;
    b_dbgl = 1'b0; b_dtackl = 1'b0; b_edi = 8'h0;

    // Reset held three cycles with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst ctrl", 64'({a_ack, a_done, a_err, a_strb, a_edoe, a_dreql, a_erw}), 64'(7'b0000011));
      chk("rst ea/ed_o", 64'({a_ea, a_edo}), 64'(0));
      chk("rst rdata", 64'(a_rdata), 64'(0));
      chk("rst b ack/dreql", 64'({b_ack, b_dreql, b_strb}), 64'(3'b010));
    end
    resetl = 1'b1; a_mreq = 1'b0; b_mreq = 1'b0;

    for (int i = 0; i < 13; i++) run_a(vt[i], i);

    // Back-to-back: mreq held through DONE keeps dreql low and re-acks
    @(negedge clk);
    a_mreq = 1'b1; a_rw = 1'b1; a_size = 2'd1; a_addr = 24'h500; a_be = 1'b1; a_edi = 16'h1111;
    @(negedge clk); chk("b2b ack1", 64'(a_ack), 64'(1));
    @(negedge clk); chk("b2b strb1", 64'({a_strb, a_ea}), 64'({1'b1, 24'h500}));
    @(negedge clk); chk("b2b done1", 64'({a_done, a_dreql}), 64'(2'b10));
    chk("b2b rdata1", 64'(a_rdata), 64'(16'h1111));
    a_edi = 16'h2222;
    @(negedge clk); chk("b2b ack2", 64'({a_ack, a_dreql, a_done}), 64'(3'b100));
    a_mreq = 1'b0;
    @(negedge clk); chk("b2b strb2", 64'(a_strb), 64'(1));
    @(negedge clk); chk("b2b done2", 64'(a_done), 64'(1));
    chk("b2b rdata2", 64'(a_rdata), 64'(16'h2222));
    @(negedge clk); chk("b2b release", 64'(a_dreql), 64'(1));

    // Grant lost during GAP: second beat waits for regrant
    @(negedge clk);
    a_mreq = 1'b1; a_rw = 1'b1; a_size = 2'd2; a_addr = 24'h400; a_be = 1'b1;
    @(negedge clk); chk("gl ack", 64'(a_ack), 64'(1)); a_mreq = 1'b0;
    @(negedge clk); chk("gl beat0", 64'({a_strb, a_ea}), 64'({1'b1, 24'h400}));
    a_edi = 16'hA1A2; a_dbgl = 1'b1;
    @(negedge clk); chk("gl gap", 64'(a_strb), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("gl req hold", 64'({a_strb, a_dreql}), 64'(2'b00));
    end
    a_dbgl = 1'b0;
    @(negedge clk); chk("gl beat1", 64'({a_strb, a_ea}), 64'({1'b1, 24'h402}));
    a_edi = 16'hB1B2;
    @(negedge clk); chk("gl done", 64'(a_done), 64'(1));
    chk("gl rdata", 64'(a_rdata), 64'(32'hA1A2B1B2));

    // Timeout: no dtack, err after four BEAT cycles
    @(negedge clk);
    a_mreq = 1'b1; a_rw = 1'b1; a_size = 2'd1; a_addr = 24'h600; a_dtackl = 1'b1;
    cnt = 0; ecyc = -1; dr_at_err = 1'b0; any_bad = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_mreq = 1'b0;
      if (a_strb) cnt++;
      if (a_err && ecyc < 0) begin ecyc = cyc; dr_at_err = a_dreql; end
      if (a_done) any_bad = 1'b1;
    end
    chk("tmo beat cycles", 64'(cnt), 64'(4));
    chk("tmo err cycle", 64'(ecyc), 64'(6));
    chk("tmo dreql", 64'(dr_at_err), 64'(1));
    chk("tmo no done", 64'(any_bad), 64'(0));

    // dtack on the expiry edge wins over the timeout
    @(negedge clk);
    a_mreq = 1'b1; a_addr = 24'h700; a_edi = 16'h7777; a_dtackl = 1'b1;
    cnt = 0; dcyc = -1; any_bad = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_mreq = 1'b0;
      if (a_strb) begin cnt++; if (cnt == 4) a_dtackl = 1'b0; end
      if (a_err) any_bad = 1'b1;
      if (a_done && dcyc < 0) begin dcyc = cyc; chk("edge rdata", 64'(a_rdata), 64'(16'h7777)); end
    end
    a_dtackl = 1'b0;
    chk("edge done cycle", 64'(dcyc), 64'(6));
    chk("edge no err", 64'(any_bad), 64'(0));

    // Reset in the middle of a beat aborts silently
    @(negedge clk);
    a_mreq = 1'b1; a_addr = 24'h800; a_dtackl = 1'b1;
    @(negedge clk); a_mreq = 1'b0;
    @(negedge clk); chk("mid strb", 64'(a_strb), 64'(1)); resetl = 1'b0;
    @(negedge clk); chk("mid rst", 64'({a_strb, a_dreql, a_err, a_done}), 64'(4'b0100));
    resetl = 1'b1; a_dtackl = 1'b0;
    any_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_done || a_err || a_strb) any_bad = 1'b1;
    end
    chk("mid quiet", 64'(any_bad), 64'(0));

    run_b("b64 le wr", 1'b0, 1'b0, 24'h40, 64'h0807060504030201, 64'h0807060504030201, 64'h0);
    run_b("b64 be wr", 1'b0, 1'b1, 24'h48, 64'h0807060504030201, 64'h0102030405060708, 64'h0);
    run_b("b64 be rd", 1'b1, 1'b1, 24'h80, 64'h0, 64'h0, 64'h1122334455667788);
    run_b("b64 le rd", 1'b1, 1'b0, 24'hC0, 64'h0, 64'h0, 64'h8877665544332211);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
